// File: rtl/memwb_pipe_reg_if.sv
// MEM/WB stage link: one entry of write-back payload with a valid/ready handshake.
// A transfer happens on a rising edge where valid & ready are both 1; the master holds the payload stable while valid & ~ready.
interface memwb_pipe_reg_if #(
    parameter int WB_W   = 2,
    parameter int RD_W   = 5,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [WB_W-1:0]   wb;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (output valid, wb, rd, addr, data, input ready);
    modport slave  (input valid, wb, rd, addr, data, output ready);
endinterface

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with an optional skid entry, synchronous flush,
// masking of WB/rd on bubbles and a saturating retired-entry counter.
module memwb_pipe_reg #(
    parameter int WB_W   = 2,
    parameter int RD_W   = 5,
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    memwb_pipe_reg_if.slave  up,
    memwb_pipe_reg_if.master dn,
    output logic [CNT_W-1:0] retired_o,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKIDS = 2'b10
    } state_e;

    localparam int PW = WB_W + RD_W + 2 * DATA_W;

    state_e        state;
    state_e        next_state;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] in_pay;
    logic          main_valid;
    logic          skid_valid;
    logic          in_xfer;
    logic          out_xfer;
    logic          load_main;
    logic          load_skid;
    logic          main_from_skid;

    assign in_pay     = {up.wb, up.rd, up.addr, up.data};
    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == SKIDS);

    // With a skid entry, ready depends only on the state register, never on dn.ready.
    assign up.ready = (SKID != 0) ? ~skid_valid : (~main_valid | dn.ready);
    assign in_xfer  = up.valid & up.ready;
    assign out_xfer = main_valid & dn.ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        next_state = FULL;
                        load_main  = 1'b1;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        next_state = SKIDS;
                        load_skid  = 1'b1;
                    end else if (out_xfer) begin
                        next_state = EMPTY;
                    end
                end
                SKIDS: begin
                    if (out_xfer) begin
                        next_state     = FULL;
                        main_from_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // Payload only moves on a load; a stalled main entry stays untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_pay;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_pay;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retired_o <= '0;
        end else if (out_xfer && (retired_o != {CNT_W{1'b1}})) begin
            retired_o <= retired_o + 1'b1;
        end
    end

    assign dn.valid  = main_valid;
    assign dn.wb     = main_valid ? main_q[PW-1 -: WB_W] : '0;
    assign dn.rd     = main_valid ? main_q[2*DATA_W +: RD_W] : '0;
    assign dn.addr   = main_q[DATA_W +: DATA_W];
    assign dn.data   = main_q[DATA_W-1:0];
    assign dbg_state = state;
endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Bench for memwb_pipe_reg: three instances (skid, no skid, 4-bit counter) share one
// stimulus stream; each is tracked by a bounded-FIFO model with a saturating counter.
module tb_memwb_pipe_reg;
    localparam int WB_W   = 2;
    localparam int RD_W   = 5;
    localparam int DATA_W = 32;
    localparam int PW     = WB_W + RD_W + 2 * DATA_W;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              flush    = 1'b0;
    logic              valid_in = 1'b0;
    logic              ready_in = 1'b0;
    logic [WB_W-1:0]   wb_in    = '0;
    logic [RD_W-1:0]   rd_in    = '0;
    logic [DATA_W-1:0] addr_in  = '0;
    logic [DATA_W-1:0] data_in  = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    memwb_pipe_reg_if #(.WB_W(WB_W), .RD_W(RD_W), .DATA_W(DATA_W)) up0 ();
    memwb_pipe_reg_if #(.WB_W(WB_W), .RD_W(RD_W), .DATA_W(DATA_W)) dn0 ();
    memwb_pipe_reg_if #(.WB_W(WB_W), .RD_W(RD_W), .DATA_W(DATA_W)) up1 ();
    memwb_pipe_reg_if #(.WB_W(WB_W), .RD_W(RD_W), .DATA_W(DATA_W)) dn1 ();
    memwb_pipe_reg_if #(.WB_W(WB_W), .RD_W(RD_W), .DATA_W(DATA_W)) up2 ();
    memwb_pipe_reg_if #(.WB_W(WB_W), .RD_W(RD_W), .DATA_W(DATA_W)) dn2 ();

    logic [15:0] ret0, ret1;
    logic [3:0]  ret2;
    logic [1:0]  st0, st1, st2;

    assign up0.valid = valid_in; assign up0.wb = wb_in; assign up0.rd = rd_in;
    assign up0.addr = addr_in;   assign up0.data = data_in; assign dn0.ready = ready_in;
    assign up1.valid = valid_in; assign up1.wb = wb_in; assign up1.rd = rd_in;
    assign up1.addr = addr_in;   assign up1.data = data_in; assign dn1.ready = ready_in;
    assign up2.valid = valid_in; assign up2.wb = wb_in; assign up2.rd = rd_in;
    assign up2.addr = addr_in;   assign up2.data = data_in; assign dn2.ready = ready_in;

    memwb_pipe_reg #(.WB_W(WB_W), .RD_W(RD_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .up(up0.slave), .dn(dn0.master),
        .retired_o(ret0), .dbg_state(st0));
    memwb_pipe_reg #(.WB_W(WB_W), .RD_W(RD_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .up(up1.slave), .dn(dn1.master),
        .retired_o(ret1), .dbg_state(st1));
    memwb_pipe_reg #(.WB_W(WB_W), .RD_W(RD_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .up(up2.slave), .dn(dn2.master),
        .retired_o(ret2), .dbg_state(st2));

    logic [2:0]    o_valid;
    logic [2:0]    o_ready;
    logic [PW-1:0] o_pay [3];
    logic [15:0]   o_ret [3];

    assign o_valid = {dn2.valid, dn1.valid, dn0.valid};
    assign o_ready = {up2.ready, up1.ready, up0.ready};
    assign o_pay[0] = {dn0.wb, dn0.rd, dn0.addr, dn0.data};
    assign o_pay[1] = {dn1.wb, dn1.rd, dn1.addr, dn1.data};
    assign o_pay[2] = {dn2.wb, dn2.rd, dn2.addr, dn2.data};
    assign o_ret[0] = ret0;
    assign o_ret[1] = ret1;
    assign o_ret[2] = {12'd0, ret2};

    // ---------------- model: bounded FIFO + saturating count ----------------
    logic [PW-1:0] exp_q0[$];
    logic [PW-1:0] exp_q1[$];
    logic [PW-1:0] exp_q2[$];
    int mret [3];
    int cap  [3] = '{2, 1, 2};
    int rmax [3] = '{65535, 65535, 15};

    function automatic int qsize(int k);
        if (k == 0) return exp_q0.size();
        if (k == 1) return exp_q1.size();
        return exp_q2.size();
    endfunction

    function automatic logic [PW-1:0] qfront(int k);
        if (k == 0) return exp_q0[0];
        if (k == 1) return exp_q1[0];
        return exp_q2[0];
    endfunction

    function automatic void qpush(int k, logic [PW-1:0] x);
        if (k == 0) exp_q0.push_back(x);
        else if (k == 1) exp_q1.push_back(x);
        else exp_q2.push_back(x);
    endfunction

    function automatic void qpop(int k);
        if (k == 0) void'(exp_q0.pop_front());
        else if (k == 1) void'(exp_q1.pop_front());
        else void'(exp_q2.pop_front());
    endfunction

    function automatic void qclear(int k);
        if (k == 0) exp_q0.delete();
        else if (k == 1) exp_q1.delete();
        else exp_q2.delete();
    endfunction

    function automatic logic [PW-1:0] pay(logic [WB_W-1:0] w, logic [RD_W-1:0] r,
                                          logic [DATA_W-1:0] a, logic [DATA_W-1:0] d);
        return {w, r, a, d};
    endfunction

    task automatic chk(input string name, input int k, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
        end
    endtask

    // Compare every instance against its model, then advance the model to the next edge.
    logic [PW-1:0] mask, exp_p;
    logic          m_ready, in_x, out_x, m_valid;
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                qclear(k);
                mret[k] = 0;
                chk("rst_valid", k, o_valid[k], 0);
                chk("rst_payload", k, o_pay[k], 0);
                chk("rst_retired", k, o_ret[k], 0);
            end else begin
                m_valid = (qsize(k) > 0);
                m_ready = (cap[k] == 2) ? (qsize(k) < 2) : (qsize(k) == 0 || ready_in);
                mask    = m_valid ? {PW{1'b1}} : {{(WB_W+RD_W){1'b1}}, {(2*DATA_W){1'b0}}};
                exp_p   = m_valid ? qfront(k) : '0;
                chk("valid_o", k, o_valid[k], m_valid);
                chk("ready_o", k, o_ready[k], m_ready);
                chk("payload", k, o_pay[k] & mask, exp_p);
                chk("retired", k, o_ret[k], mret[k]);
                in_x  = valid_in && m_ready;
                out_x = m_valid && ready_in;
                if (flush) begin
                    qclear(k);
                end else begin
                    if (out_x) qpop(k);
                    if (in_x) qpush(k, {wb_in, rd_in, addr_in, data_in});
                end
                if (out_x && mret[k] < rmax[k]) mret[k]++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WB_W-1:0] w, input logic [RD_W-1:0] r,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
        valid_in = 1'b1;
        wb_in    = w;
        rd_in    = r;
        addr_in  = a;
        data_in  = d;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        valid_in = 1'b0;
        flush    = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        // 1: single entry, latency 1, counter one cycle later
        chk("reset_ready", 0, o_ready[0], 1);
        chk("reset_state", 0, st0, 0);
        ready_in = 1'b1;
        drive(2'b01, 5'd8, 32'h10, 32'hDEAD);
        step();
        valid_in = 1'b0;
        chk("t1_valid", 0, o_valid[0], 1);
        chk("t1_payload", 0, o_pay[0], pay(2'b01, 5'd8, 32'h10, 32'hDEAD));
        chk("t1_ret_before", 0, o_ret[0], 0);
        step();
        chk("t1_ret_after", 0, o_ret[0], 1);
        chk("t1_bubble_valid", 0, o_valid[0], 0);
        chk("t1_bubble_wb_rd", 0, o_pay[0][PW-1:2*DATA_W], 0);

        // 2: stall fills main and skid, then drains A,B,C in order
        do_reset();
        ready_in = 1'b0;
        drive(2'd3, 5'd1, 32'hA, 32'h1A);
        step();
        drive(2'd2, 5'd2, 32'hB, 32'h1B);
        step();
        drive(2'd1, 5'd3, 32'hC, 32'h1C);
        chk("t2_ready_low", 0, o_ready[0], 0);
        chk("t2_hold_a", 0, o_pay[0], pay(2'd3, 5'd1, 32'hA, 32'h1A));
        step();
        chk("t2_still_a", 0, o_pay[0], pay(2'd3, 5'd1, 32'hA, 32'h1A));
        ready_in = 1'b1;
        step();
        chk("t2_b", 0, o_pay[0], pay(2'd2, 5'd2, 32'hB, 32'h1B));
        chk("t2_ready_back", 0, o_ready[0], 1);
        step();
        valid_in = 1'b0;
        chk("t2_c", 0, o_pay[0], pay(2'd1, 5'd3, 32'hC, 32'h1C));
        step();
        chk("t2_empty", 0, o_valid[0], 0);
        chk("t2_ret", 0, o_ret[0], 3);

        // 3: flush while both entries held, with a concurrent input
        do_reset();
        ready_in = 1'b0;
        drive(2'd3, 5'd4, 32'h40, 32'h44);
        step();
        drive(2'd3, 5'd5, 32'h50, 32'h55);
        step();
        flush = 1'b1;
        drive(2'd3, 5'd6, 32'h60, 32'h66);
        step();
        flush    = 1'b0;
        valid_in = 1'b0;
        chk("t3_valid", 0, o_valid[0], 0);
        chk("t3_wb_rd", 0, o_pay[0][PW-1:2*DATA_W], 0);
        chk("t3_ready", 0, o_ready[0], 1);
        ready_in = 1'b1;
        step();
        step();
        chk("t3_nothing_out", 0, o_valid[0], 0);
        chk("t3_ret", 0, o_ret[0], 0);

        // 4: single-entry instance streams at full rate
        do_reset();
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(2'd1, RD_W'(i), 32'd100 + 32'(i), 32'd200 + 32'(i));
            step();
            chk("t4_stream", 1, {o_valid[1], o_pay[1]},
                {1'b1, pay(2'd1, RD_W'(i), 32'd100 + 32'(i), 32'd200 + 32'(i))});
        end
        valid_in = 1'b0;
        step();
        chk("t4_ret", 1, o_ret[1], 8);

        // 5: 4-bit counter saturates
        do_reset();
        ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom);
            step();
        end
        valid_in = 1'b0;
        step();
        step();
        chk("t5_sat", 2, o_ret[2], 15);
        chk("t5_wide", 0, o_ret[0], 20);

        // 6: asynchronous reset between edges
        do_reset();
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(2'd3, 5'd9, $urandom, $urandom);
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", 0, o_valid[0], 0);
        chk("t6_async_payload", 0, o_pay[0], 0);
        chk("t6_async_ret", 0, o_ret[0], 0);
        valid_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        drive(2'd2, 5'd17, 32'h1234, 32'h5678);
        step();
        valid_in = 1'b0;
        chk("t6_after", 0, o_pay[0], pay(2'd2, 5'd17, 32'h1234, 32'h5678));
        step();
        chk("t6_ret", 0, o_ret[0], 1);

        // random traffic with stalls and occasional flushes
        do_reset();
        for (int i = 0; i < 400; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            ready_in = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            wb_in    = 2'($urandom_range(0, 3));
            rd_in    = 5'($urandom_range(0, 31));
            addr_in  = $urandom;
            data_in  = $urandom;
            step();
        end
        flush    = 1'b0;
        valid_in = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
